// File: rtl/riscv_cache_biu_arb_if.sv
// Cache-side and BIU-side signal bundle for riscv_cache_biu_arb.
// Per-port request fields are packed [port][field]; the arbiter uses the slave modport.
interface riscv_cache_biu_arb_if #(
    parameter int XLEN           = 32,
    parameter int PLEN           = (XLEN == 32) ? 34 : 56,
    parameter int INFLIGHT_DEPTH = 2
);
    localparam int INFLIGHT_BITS = $clog2(INFLIGHT_DEPTH + 1);

    // Cache hit stages (port 0 = data cache, port 1 = instruction cache)
    logic [1:0][1:0]      req_biucmd_i;
    logic [1:0]           req_nc_i;
    logic [1:0][PLEN-1:0] req_adr_i;
    logic [1:0][2:0]      req_size_i;
    logic [1:0][2:0]      req_prot_i;
    logic [1:0]           req_we_i;
    logic [1:0][XLEN-1:0] req_d_i;
    logic [1:0]           gnt_o;
    logic [1:0]           req_biucmd_ack_o;
    logic [1:0]           req_stb_ack_o;
    logic [1:0]           req_ack_o;
    logic [1:0]           req_err_o;
    logic [XLEN-1:0]      req_q_o;
    logic [INFLIGHT_BITS-1:0] req_inflight_o;

    // BIU
    logic [1:0]           biucmd_o;
    logic                 biu_stb_o;
    logic [PLEN-1:0]      biu_adri_o;
    logic [2:0]           biu_size_o;
    logic [2:0]           biu_prot_o;
    logic                 biu_we_o;
    logic [XLEN-1:0]      biu_d_o;
    logic                 biucmd_ack_i;
    logic                 biu_stb_ack_i;
    logic                 biu_ack_i;
    logic                 biu_err_i;
    logic [XLEN-1:0]      biu_q_i;

    modport slave (
        input  req_biucmd_i, req_nc_i, req_adr_i, req_size_i, req_prot_i, req_we_i, req_d_i,
        output gnt_o, req_biucmd_ack_o, req_stb_ack_o, req_ack_o, req_err_o, req_q_o,
               req_inflight_o,
        output biucmd_o, biu_stb_o, biu_adri_o, biu_size_o, biu_prot_o, biu_we_o, biu_d_o,
        input  biucmd_ack_i, biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i
    );

    modport master (
        output req_biucmd_i, req_nc_i, req_adr_i, req_size_i, req_prot_i, req_we_i, req_d_i,
        input  gnt_o, req_biucmd_ack_o, req_stb_ack_o, req_ack_o, req_err_o, req_q_o,
               req_inflight_o,
        input  biucmd_o, biu_stb_o, biu_adri_o, biu_size_o, biu_prot_o, biu_we_o, biu_d_o,
        output biucmd_ack_i, biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i
    );
endinterface

// File: rtl/riscv_cache_biu_arb.sv
// Two-port (dcache=0, icache=1) arbiter sharing one BIU port; grant held until drained.
// Define RV_CACHE_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties), else round-robin.
package riscv_cache_biu_arb_pkg;
    typedef enum logic [1:0] {
        BIUCMD_NOP      = 2'd0,
        BIUCMD_READWAY  = 2'd1,
        BIUCMD_WRITEWAY = 2'd2
    } biucmd_t;

    typedef logic [2:0] biu_size_t;
    typedef logic [2:0] biu_prot_t;
endpackage

module riscv_cache_biu_arb
    import riscv_cache_biu_arb_pkg::*;
#(
    parameter int INFLIGHT_DEPTH = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    riscv_cache_biu_arb_if.slave bus
);
    localparam int INFLIGHT_BITS = $clog2(INFLIGHT_DEPTH + 1);
    localparam logic [INFLIGHT_BITS-1:0] INFLIGHT_MAX = INFLIGHT_BITS'(INFLIGHT_DEPTH);
    localparam logic [INFLIGHT_BITS-1:0] INFLIGHT_ONE = INFLIGHT_BITS'(1);

    typedef enum logic [1:0] {IDLE, WAY, NC} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               gnt_q, gnt_d;
    logic [INFLIGHT_BITS-1:0] inflight_q, inflight_d;
`ifndef RV_CACHE_ARB_FIXED_PRIO_EN
    logic                     last_q, last_d;
`endif

    logic       owner, winner;
    logic       stb, stb_accept, rsp_retire;
    logic [1:0] req_vld;
    biucmd_t    biucmd;
    logic [1:0] biucmd_ack, stb_ack, ack, err;

    assign owner = gnt_q[1];

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            req_vld[n] = (bus.req_biucmd_i[n] != BIUCMD_NOP) || bus.req_nc_i[n];
        end
`ifdef RV_CACHE_ARB_FIXED_PRIO_EN
        winner = !req_vld[0];
`else
        // On a tie the port that did not win last time goes next.
        winner = (&req_vld) ? !last_q : req_vld[1];
`endif
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        inflight_d = inflight_q;
`ifndef RV_CACHE_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        biucmd     = BIUCMD_NOP;
        stb        = 1'b0;
        stb_accept = 1'b0;
        rsp_retire = 1'b0;
        biucmd_ack = '0;
        stb_ack    = '0;
        ack        = '0;
        err        = '0;

        unique case (state_q)
            IDLE: begin
                if (|req_vld) begin
                    gnt_d   = 2'b01 << winner;
`ifndef RV_CACHE_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                    state_d = (bus.req_biucmd_i[winner] != BIUCMD_NOP) ? WAY : NC;
                end
            end
            WAY: begin
                biucmd            = biucmd_t'(bus.req_biucmd_i[owner]);
                biucmd_ack[owner] = bus.biucmd_ack_i;
                ack[owner]        = bus.biu_ack_i;
                err[owner]        = bus.biu_err_i;
                if (bus.biucmd_ack_i || bus.biu_err_i) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            NC: begin
                stb            = bus.req_nc_i[owner] && (inflight_q < INFLIGHT_MAX);
                stb_accept     = stb && bus.biu_stb_ack_i;
                rsp_retire     = (bus.biu_ack_i || bus.biu_err_i) && (inflight_q != '0);
                stb_ack[owner] = stb_accept;
                ack[owner]     = bus.biu_ack_i;
                err[owner]     = bus.biu_err_i;
                unique case ({stb_accept, rsp_retire})
                    2'b10:   inflight_d = inflight_q + INFLIGHT_ONE;
                    2'b01:   inflight_d = inflight_q - INFLIGHT_ONE;
                    default: inflight_d = inflight_q;
                endcase
                // Exit in the same cycle as the final response once the owner stops asking.
                if (!bus.req_nc_i[owner] && inflight_d == '0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            inflight_q <= '0;
`ifndef RV_CACHE_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            inflight_q <= inflight_d;
`ifndef RV_CACHE_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.gnt_o            = gnt_q;
    assign bus.req_biucmd_ack_o = biucmd_ack;
    assign bus.req_stb_ack_o    = stb_ack;
    assign bus.req_ack_o        = ack;
    assign bus.req_err_o        = err;
    assign bus.req_q_o          = bus.biu_q_i;
    assign bus.req_inflight_o   = inflight_q;

    assign bus.biucmd_o   = biucmd;
    assign bus.biu_stb_o  = stb;
    assign bus.biu_adri_o = bus.req_adr_i[owner];
    assign bus.biu_size_o = bus.req_size_i[owner];
    assign bus.biu_prot_o = bus.req_prot_i[owner];
    assign bus.biu_we_o   = bus.req_we_i[owner];
    assign bus.biu_d_o    = bus.req_d_i[owner];
endmodule

// File: doc/riscv_cache_biu_arb.md
Name: riscv_cache_biu_arb

Overview:
- Shares one BIU command/data port between two cache hit stages: port 0 is the data cache, port 1 is the instruction cache.
- Arbitrates way fills/evictions (biucmd_t commands) and non-cacheable single transfers.
- Holds a grant until the owner's transaction fully drains, then routes BIU responses back to the owner only.
- Sits between the cache hit stages and the BIU.

Parameters:
- XLEN, 32, data width.
- PLEN, XLEN==32 ? 34 : 56, physical address width.
- INFLIGHT_DEPTH, 2, maximum outstanding non-cacheable transfers.
- INFLIGHT_BITS, $clog2(INFLIGHT_DEPTH+1), width of the inflight count (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_biucmd_i  in  2 x biucmd_t  per-port way command (NOP/READWAY/WRITEWAY)
- req_nc_i  in  2  per-port non-cacheable request
- req_adr_i  in  2 x PLEN  per-port address
- req_size_i  in  2 x biu_size_t  per-port transfer size
- req_prot_i  in  2 x biu_prot_t  per-port protection
- req_we_i  in  2  per-port write enable
- req_d_i  in  2 x XLEN  per-port write data
- gnt_o  out  2  one-hot owner (registered)
- req_biucmd_ack_o  out  2  way command acknowledge to owner
- req_stb_ack_o  out  2  non-cacheable strobe acknowledge to owner
- req_ack_o  out  2  data acknowledge to owner
- req_err_o  out  2  error to owner
- req_q_o  out  XLEN  BIU read data (broadcast; qualify with req_ack_o)
- req_inflight_o  out  INFLIGHT_BITS  outstanding non-cacheable count (owner's)
- biucmd_o  out  biucmd_t  way command to BIU
- biu_stb_o  out  1  non-cacheable strobe
- biu_adri_o  out  PLEN  address
- biu_size_o  out  biu_size_t  size
- biu_prot_o  out  biu_prot_t  protection
- biu_we_o  out  1  write enable
- biu_d_o  out  XLEN  write data
- biucmd_ack_i  in  1  way command complete
- biu_stb_ack_i  in  1  strobe accepted
- biu_ack_i  in  1  data acknowledge
- biu_err_i  in  1  bus error
- biu_q_i  in  XLEN  read data

Behaviour:
- Reset:
  - state=IDLE, gnt_o=0, last=1 (port 0 wins first), inflight=0.
  - biucmd_o=BIUCMD_NOP, biu_stb_o=0.
  - All req_*_o responses 0.
- Port n is requesting when req_biucmd_i[n]!=BIUCMD_NOP or req_nc_i[n]=1.
- FSM states: IDLE, WAY, NC.
- IDLE:
  - Pick a winner among requesting ports. Round-robin: the port != last wins a tie. A single requester wins outright.
  - Register gnt_o and last<=winner.
  - If the winner's biucmd!=NOP, go to WAY. The way command takes precedence over req_nc_i on the same port.
  - Otherwise go to NC.
  - No BIU activity in the grant cycle. The grant-to-first-command latency is 1 cycle.
- Mux: while gnt_o[n]=1, biucmd_o, biu_adri_o, biu_size_o, biu_prot_o, biu_we_o and biu_d_o follow port n combinationally. Otherwise biucmd_o=NOP, biu_stb_o=0, and the remaining BIU outputs are don't-care.
- WAY:
  - biucmd_o=req_biucmd_i[owner]; biu_stb_o=0.
  - On biucmd_ack_i or biu_err_i: pulse req_biucmd_ack_o/req_err_o to the owner, return to IDLE, clear gnt_o.
  - biu_ack_i during WAY is routed to the owner as req_ack_o (streaming fill beats).
- NC:
  - biu_stb_o = req_nc_i[owner] & (inflight<INFLIGHT_DEPTH).
  - req_stb_ack_o[owner] = biu_stb_ack_i & biu_stb_o.
- Inflight counter: +1 on an accepted strobe; -1 on biu_ack_i or biu_err_i. If both occur in one cycle the count is unchanged.
  - Never exceeds INFLIGHT_DEPTH.
  - An ack/err with inflight=0 is ignored; the counter does not underflow.
- NC exit: when req_nc_i[owner]=0 and the next inflight is 0, go to IDLE and clear gnt_o. Exit is therefore allowed in the same cycle as the last ack.
- An owner switching from req_nc_i to a biucmd while inflight>0 keeps the grant. The way command is issued only after an IDLE pass (drain first).
- The non-owner's requests are ignored, and its response outputs stay 0, throughout WAY/NC.
- A requester dropping its request while in IDLE before the grant registers is harmless: the grant registers, then the next cycle exits.
- Error in NC: req_err_o pulses to the owner and inflight decrements; the grant is retained until drained.
- Asynchronous reset mid-transaction returns to the reset values immediately. Outstanding BIU responses after reset are discarded because no owner exists.

Optional Feature:
- Macro: RV_CACHE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 (data cache) always wins an IDLE tie; the last register is unused.
- Undefined: round-robin as above.

Test Plan:
- Both ports request READWAY in the same cycle after reset -> gnt_o=2'b01 next cycle, biucmd_o=READWAY from port 0. Four biu_ack_i beats go to req_ack_o[0] only. biucmd_ack_i -> IDLE, then gnt_o=2'b10 within 2 cycles.
- Port 1 holds req_nc_i with INFLIGHT_DEPTH=2 and no biu_ack_i -> two stb acks, then biu_stb_o=0, inflight=2. One ack -> inflight=1 and biu_stb_o reasserts.
- Port 1 drops req_nc_i with inflight=1; biu_ack_i arrives -> same-cycle exit, gnt_o=0 next cycle, inflight=0.
- biu_err_i during port 0 WRITEWAY -> req_err_o[0] pulses 1 cycle, return to IDLE. req_err_o[1] stays 0.
- Assert rst_ni low while in NC with inflight=2 -> gnt_o=0, biu_stb_o=0, inflight=0 immediately. A later biu_ack_i produces no req_ack_o.
- With RV_CACHE_ARB_FIXED_PRIO_EN, both ports request back-to-back 3 times -> port 0 is granted every time. Without the macro, grants alternate 01, 10, 01.
